// File: rtl/uart_mmio_pkg.sv
// ---------------------------------------------------------------------------
// uart_mmio_pkg
// Shared definitions for the memory-mapped UART responder:
//   - bus addresses of the three UART registers (exact-match decode)
//   - bit positions inside the UCON control/status register
//   - state enumerations for the TX and RX framing FSMs
// ---------------------------------------------------------------------------
package uart_mmio_pkg;

   localparam logic [31:0] ADDR_TXD  = 32'h4000_0018;
   localparam logic [31:0] ADDR_RXD  = 32'h4000_001C;
   localparam logic [31:0] ADDR_UCON = 32'h4000_0020;

   localparam int UCON_TX_IRQ_EN = 0;
   localparam int UCON_RX_IRQ_EN = 1;
   localparam int UCON_RX_VALID  = 2;
   localparam int UCON_TX_BUSY   = 3;
   localparam int UCON_TX_DONE   = 4;
   localparam int UCON_OVERRUN   = 5;
   localparam int UCON_FRAME_ERR = 6;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/uart_mmio_responder_if.sv
// ---------------------------------------------------------------------------
// uart_mmio_responder_if
// MEM-stage data bus as seen by the UART responder.
//   rd    : read strobe                 (master -> slave)
//   wr    : write strobe                (master -> slave)
//   addr  : full byte address           (master -> slave)
//   wdata : low byte of store data      (master -> slave)
//   rdata : same-cycle read data        (slave  -> master)
// ---------------------------------------------------------------------------
interface uart_mmio_responder_if;
   logic        rd;
   logic        wr;
   logic [31:0] addr;
   logic [7:0]  wdata;
   logic [31:0] rdata;

   modport master (output rd, output wr, output addr, output wdata, input rdata);
   modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_mmio_responder_rx_fsm.sv
// ---------------------------------------------------------------------------
// uart_rx_fsm
// 8N1 receiver: 2-flop synchroniser on the serial input, start-bit
// qualification at half a bit, eight LSB-first data samples, stop sample.
// Ports:
//   sys_clk     : system clock (rising edge)
//   reset       : asynchronous active-low reset
//   i_rx        : serial input, asynchronous to sys_clk
//   o_byte      : last assembled byte (valid when o_done pulses)
//   o_done      : one-cycle pulse, frame ended with a good stop bit
//   o_frame_err : one-cycle pulse, frame ended with a bad stop bit
// ---------------------------------------------------------------------------
module uart_rx_fsm
   import uart_mmio_pkg::*;
#(
   parameter int BIT_CYCLES = 16
) (
   input  logic       sys_clk,
   input  logic       reset,
   input  logic       i_rx,
   output logic [7:0] o_byte,
   output logic       o_done,
   output logic       o_frame_err
);

   localparam int              CW        = $clog2(BIT_CYCLES + 1);
   localparam logic [CW-1:0]   LAST      = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0]   HALF_LAST = CW'(BIT_CYCLES / 2 - 1);

   logic            r_sync1, r_sync2, r_sync_prev;
   rx_state_t       r_state, w_state_next;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_bit_idx;
   logic [7:0]      r_shift;
   logic            w_tick, w_tick_half;

   // Synchroniser flops reset to the idle (high) line level so that
   // leaving reset never looks like a start bit.
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         r_sync1     <= 1'b1;
         r_sync2     <= 1'b1;
         r_sync_prev <= 1'b1;
      end else begin
         r_sync1     <= i_rx;
         r_sync2     <= r_sync1;
         r_sync_prev <= r_sync2;
      end
   end

   assign w_tick      = (r_cnt == LAST);
   assign w_tick_half = (r_cnt == HALF_LAST);

   // State register
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) r_state <= RX_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         RX_IDLE:  if (!r_sync2 && r_sync_prev) w_state_next = RX_START;
         RX_START: if (w_tick_half) w_state_next = r_sync2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_tick && (r_bit_idx == 3'd7)) w_state_next = RX_STOP;
         RX_STOP:  if (w_tick) w_state_next = RX_IDLE;
         default:  w_state_next = RX_IDLE;
      endcase
   end

   // Output logic: the stop sample decides between a good byte and an error
   always_comb begin
      o_done      = 1'b0;
      o_frame_err = 1'b0;
      if (r_state == RX_STOP && w_tick) begin
         o_done      = r_sync2;
         o_frame_err = !r_sync2;
      end
   end

   assign o_byte = r_shift;

   // Bit timer, bit index and shift register. The timer restarts after the
   // half-bit start sample so data samples land in the middle of each bit.
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         r_cnt     <= '0;
         r_bit_idx <= 3'd0;
         r_shift   <= 8'd0;
      end else begin
         case (r_state)
            RX_IDLE: begin
               r_cnt     <= '0;
               r_bit_idx <= 3'd0;
            end
            RX_START: r_cnt <= w_tick_half ? '0 : r_cnt + 1'b1;
            RX_DATA: begin
               if (w_tick) begin
                  r_cnt     <= '0;
                  r_shift   <= {r_sync2, r_shift[7:1]};
                  r_bit_idx <= r_bit_idx + 3'd1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/uart_mmio_responder.sv
// ---------------------------------------------------------------------------
// uart_mmio_responder
// Memory-mapped UART on the MEM-stage bus: TXD / RXD / UCON registers,
// 8N1 serialiser, instantiated receiver and level interrupt.
// Ports:
//   sys_clk : system clock (rising edge)
//   reset   : asynchronous active-low reset
//   bus     : MEM-stage bus (slave side): rd, wr, addr, wdata -> rdata
//   uart_rx : serial input
//   uart_tx : serial output, idle high
//   irq     : level interrupt, built from flops only
// ---------------------------------------------------------------------------
module uart_mmio_responder
   import uart_mmio_pkg::*;
#(
   parameter int CLK_FREQ = 100000000,
   parameter int BAUD     = 9600
) (
   input  logic                   sys_clk,
   input  logic                   reset,
   uart_mmio_responder_if.slave   bus,
   input  logic                   uart_rx,
   output logic                   uart_tx,
   output logic                   irq
);

   localparam int            BIT_CYCLES = CLK_FREQ / BAUD;
   localparam int            CW         = $clog2(BIT_CYCLES + 1);
   localparam logic [CW-1:0] LAST       = CW'(BIT_CYCLES - 1);

   // Register state
   logic [7:0]    r_txd, r_rxd;
   logic          r_rx_valid, r_tx_irq_en, r_rx_irq_en;
   logic          r_tx_done, r_overrun, r_frame_err;
   logic          r_tx_line;

   // TX FSM state
   tx_state_t     r_tx_state, w_tx_state_next;
   logic [CW-1:0] r_tx_cnt;
   logic [2:0]    r_tx_bit;
   logic          w_tx_tick, w_tx_bit, w_tx_finish, w_tx_busy;

   // Decode
   logic w_sel_txd, w_sel_rxd, w_sel_ucon;
   logic w_rd_rxd, w_rd_ucon, w_wr_ucon, w_tx_accept;
   logic [31:0] w_ucon;

   // Receiver outputs
   logic [7:0] w_rx_byte;
   logic       w_rx_done, w_rx_ferr;

   assign w_sel_txd   = (bus.addr == ADDR_TXD);
   assign w_sel_rxd   = (bus.addr == ADDR_RXD);
   assign w_sel_ucon  = (bus.addr == ADDR_UCON);
   assign w_rd_rxd    = bus.rd && w_sel_rxd;
   assign w_rd_ucon   = bus.rd && w_sel_ucon;
   assign w_wr_ucon   = bus.wr && w_sel_ucon;
   assign w_tx_busy   = (r_tx_state != TX_IDLE);
   assign w_tx_accept = bus.wr && w_sel_txd && !w_tx_busy;

   uart_rx_fsm #(.BIT_CYCLES(BIT_CYCLES)) u_rx (
      .sys_clk     (sys_clk),
      .reset       (reset),
      .i_rx        (uart_rx),
      .o_byte      (w_rx_byte),
      .o_done      (w_rx_done),
      .o_frame_err (w_rx_ferr)
   );

   // ---------------- TX FSM ----------------
   assign w_tx_tick = (r_tx_cnt == LAST);

   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) r_tx_state <= TX_IDLE;
      else        r_tx_state <= w_tx_state_next;
   end

   always_comb begin
      w_tx_state_next = r_tx_state;
      case (r_tx_state)
         TX_IDLE:  if (w_tx_accept) w_tx_state_next = TX_START;
         TX_START: if (w_tx_tick) w_tx_state_next = TX_DATA;
         TX_DATA:  if (w_tx_tick && (r_tx_bit == 3'd7)) w_tx_state_next = TX_STOP;
         TX_STOP:  if (w_tx_tick) w_tx_state_next = TX_IDLE;
         default:  w_tx_state_next = TX_IDLE;
      endcase
   end

   // Line level for the current state; registered into r_tx_line so the
   // line changes one clock after the state, keeping uart_tx glitch-free.
   always_comb begin
      w_tx_bit    = 1'b1;
      w_tx_finish = 1'b0;
      case (r_tx_state)
         TX_START: w_tx_bit = 1'b0;
         TX_DATA:  w_tx_bit = r_txd[r_tx_bit];
         TX_STOP:  w_tx_finish = w_tx_tick;
         default:  w_tx_bit = 1'b1;
      endcase
   end

   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         r_tx_cnt <= '0;
         r_tx_bit <= 3'd0;
      end else begin
         if (r_tx_state == TX_IDLE || w_tx_tick) r_tx_cnt <= '0;
         else                                    r_tx_cnt <= r_tx_cnt + 1'b1;
         if (r_tx_state == TX_IDLE)              r_tx_bit <= 3'd0;
         else if (r_tx_state == TX_DATA && w_tx_tick) r_tx_bit <= r_tx_bit + 3'd1;
      end
   end

   // ---------------- Register file ----------------
   // Sticky flags: a set event in the same cycle as a clearing read wins.
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         r_txd       <= 8'd0;
         r_rxd       <= 8'd0;
         r_rx_valid  <= 1'b0;
         r_tx_irq_en <= 1'b0;
         r_rx_irq_en <= 1'b0;
         r_tx_done   <= 1'b0;
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
         r_tx_line   <= 1'b1;
      end else begin
         r_tx_line <= w_tx_bit;
         if (w_tx_accept) r_txd <= bus.wdata;
         if (w_wr_ucon) begin
            r_tx_irq_en <= bus.wdata[UCON_TX_IRQ_EN];
            r_rx_irq_en <= bus.wdata[UCON_RX_IRQ_EN];
         end
         if (w_rx_done) r_rxd <= w_rx_byte;

         if (w_rx_done)                   r_rx_valid  <= 1'b1;
         else if (w_rd_rxd)               r_rx_valid  <= 1'b0;
         if (w_rx_done && r_rx_valid)     r_overrun   <= 1'b1;
         else if (w_rd_ucon)              r_overrun   <= 1'b0;
         if (w_tx_finish)                 r_tx_done   <= 1'b1;
         else if (w_rd_ucon)              r_tx_done   <= 1'b0;
         if (w_rx_ferr)                   r_frame_err <= 1'b1;
         else if (w_rd_ucon)              r_frame_err <= 1'b0;
      end
   end

   assign w_ucon = {25'd0, r_frame_err, r_overrun, r_tx_done, w_tx_busy,
                    r_rx_valid, r_rx_irq_en, r_tx_irq_en};

   // Same-cycle read mux; returns pre-edge register contents.
   always_comb begin
      bus.rdata = 32'd0;
      if (bus.rd) begin
         if (w_sel_txd)       bus.rdata = {24'd0, r_txd};
         else if (w_sel_rxd)  bus.rdata = {24'd0, r_rxd};
         else if (w_sel_ucon) bus.rdata = w_ucon;
      end
   end

   assign uart_tx = r_tx_line;
   assign irq     = (r_tx_irq_en & r_tx_done) | (r_rx_irq_en & r_rx_valid);

endmodule

// File: tb/tb_uart_mmio_responder.sv
// ---------------------------------------------------------------------------
// tb_uart_mmio_responder
// Directed and randomized bench for uart_mmio_responder (CLK_FREQ=160,
// BAUD=10 -> 16 clocks per bit). A transaction-level model tracks register
// state and derives the TX line from the time elapsed since the accepted
// write; a negedge process compares uart_tx and irq against it every cycle.
// ---------------------------------------------------------------------------
module tb_uart_mmio_responder;
   import uart_mmio_pkg::*;

   localparam int BC    = 16;
   localparam int FRAME = 10 * BC;

   logic sys_clk = 1'b0;
   logic reset_n = 1'b0;
   logic uart_rx = 1'b1;
   logic uart_tx;
   logic irq;

   uart_mmio_responder_if bus_if ();

   uart_mmio_responder #(.CLK_FREQ(160), .BAUD(10)) dut (
      .sys_clk (sys_clk),
      .reset   (reset_n),
      .bus     (bus_if.slave),
      .uart_rx (uart_rx),
      .uart_tx (uart_tx),
      .irq     (irq)
   );

   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int errors = 0;

   // ---------------- model state ----------------
   logic [7:0] m_txd = 8'd0, m_rxd = 8'd0;
   logic m_rx_valid = 1'b0, m_tx_en = 1'b0, m_rx_en = 1'b0;
   logic m_tx_done = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
   logic m_tx_active = 1'b0;
   int   m_tx_age = 0;
   logic m_line = 1'b1;
   logic m_rx_busy = 1'b0;

   logic [31:0] last_rdata;
   logic        last_line;
   logic        tx_seq [0:FRAME];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_txd = 8'd0; m_rxd = 8'd0; m_rx_valid = 1'b0;
      m_tx_en = 1'b0; m_rx_en = 1'b0; m_tx_done = 1'b0;
      m_ovr = 1'b0; m_ferr = 1'b0; m_tx_active = 1'b0;
      m_tx_age = 0; m_line = 1'b1;
   endtask

   function automatic logic [31:0] m_reg(input logic [31:0] a);
      case (a)
         ADDR_TXD:  return {24'd0, m_txd};
         ADDR_RXD:  return {24'd0, m_rxd};
         ADDR_UCON: return {25'd0, m_ferr, m_ovr, m_tx_done, m_tx_active,
                            m_rx_valid, m_rx_en, m_tx_en};
         default:   return 32'd0;
      endcase
   endfunction

   // Line level = function of cycles elapsed since the accepted write:
   // slot 0 start, slots 1..8 data LSB first, slot 9 stop.
   task automatic model_line();
      int slot;
      if (m_tx_active && m_tx_age >= 1) begin
         slot = (m_tx_age - 1) / BC;
         if (slot == 0)      m_line = 1'b0;
         else if (slot <= 8) m_line = m_txd[slot-1];
         else                m_line = 1'b1;
      end else begin
         m_line = 1'b1;
      end
   endtask

   task automatic model_edge(input logic rd, input logic wr, input logic [31:0] a, input logic [7:0] wd);
      logic acc;
      if (!reset_n) begin model_reset(); return; end
      acc = wr && (a == ADDR_TXD) && !m_tx_active;
      if (rd && a == ADDR_RXD) m_rx_valid = 1'b0;
      if (rd && a == ADDR_UCON) begin m_tx_done = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; end
      if (wr && a == ADDR_UCON) begin m_tx_en = wd[0]; m_rx_en = wd[1]; end
      if (m_tx_active) begin
         m_tx_age++;
         if (m_tx_age == FRAME) begin m_tx_active = 1'b0; m_tx_done = 1'b1; end
      end
      if (acc) begin m_txd = wd; m_tx_active = 1'b1; m_tx_age = 0; end
      model_line();
   endtask

   // One bus cycle: drive, sample rdata mid-cycle, advance model at the edge.
   task automatic tick(input logic rd, input logic wr, input logic [31:0] a, input logic [7:0] wd);
      bus_if.rd = rd; bus_if.wr = wr; bus_if.addr = a; bus_if.wdata = wd;
      @(negedge sys_clk);
      last_rdata = bus_if.rdata;
      last_line  = uart_tx;
      check("rdata", last_rdata, rd ? m_reg(a) : 32'd0);
      @(posedge sys_clk);
      model_edge(rd, wr, a, wd);
      #1;
      bus_if.rd = 1'b0; bus_if.wr = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'd0, 8'd0);
   endtask

   task automatic bus_read(input logic [31:0] a, input logic [31:0] exp_lit, input string nm);
      tick(1'b1, 1'b0, a, 8'd0);
      $display("read  addr=0x%08h data=0x%08h", a, last_rdata);
      check(nm, last_rdata, exp_lit);
   endtask

   task automatic tx_capture(input logic [7:0] b, input bit poke);
      $display("txd   write=0x%02h", b);
      tick(1'b0, 1'b1, ADDR_TXD, b);
      for (int k = 1; k <= FRAME + 1; k++) begin
         if (poke && k == 50) tick(1'b0, 1'b1, ADDR_TXD, 8'h3C);
         else if (poke && k == 80) begin
            tick(1'b1, 1'b0, ADDR_UCON, 8'd0);
            check("ucon_busy", last_rdata, 32'h08);
         end else tick(1'b0, 1'b0, 32'd0, 8'd0);
         tx_seq[k-1] = last_line;
      end
   endtask

   task automatic check_frame(input logic [9:0] exp);
      check("tx_pre_idle", 32'(tx_seq[0]), 32'd1);
      check("tx_first_low", 32'(tx_seq[1]), 32'd0);
      check("tx_start_end", 32'(tx_seq[BC]), 32'd0);
      check("tx_bit0_begin", 32'(tx_seq[BC+1]), 32'(exp[1]));
      for (int b = 0; b < 10; b++) check("tx_frame_bit", 32'(tx_seq[BC*b+8]), 32'(exp[b]));
      check("tx_stop_end", 32'(tx_seq[FRAME]), 32'd1);
   endtask

   task automatic rx_frame(input logic [7:0] b, input bit stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      $display("rx    frame=0x%02h stop=%0d", b, stop);
      m_rx_busy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         uart_rx = f[i];
         idle(BC);
      end
      uart_rx = 1'b1;
      if (stop) begin
         if (m_rx_valid) m_ovr = 1'b1;
         m_rxd = b;
         m_rx_valid = 1'b1;
      end else begin
         m_ferr = 1'b1;
      end
      m_rx_busy = 1'b0;
      idle(4);
   endtask

   // Per-cycle output comparison against the model
   always @(negedge sys_clk) begin
      check("uart_tx", 32'(uart_tx), 32'(m_line));
      if (!m_rx_busy)
         check("irq", 32'(irq), 32'((m_tx_en & m_tx_done) | (m_rx_en & m_rx_valid)));
   end

   initial begin
      #5000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   logic [31:0] addr_pool [0:5];

   initial begin
      addr_pool[0] = ADDR_TXD;      addr_pool[1] = ADDR_RXD;
      addr_pool[2] = ADDR_UCON;     addr_pool[3] = 32'h4000_0024;
      addr_pool[4] = 32'h0000_0018; addr_pool[5] = 32'h4000_0019;
      bus_if.rd = 1'b0; bus_if.wr = 1'b0; bus_if.addr = 32'd0; bus_if.wdata = 8'd0;
      model_reset();
      repeat (3) @(posedge sys_clk);
      #1 reset_n = 1'b1;

      // Reset state
      bus_read(ADDR_UCON, 32'h0, "reset_ucon");
      check("reset_tx", 32'(last_line), 32'd1);
      bus_read(ADDR_TXD, 32'h0, "reset_txd");
      bus_read(ADDR_RXD, 32'h0, "reset_rxd");

      // TX 0xA5 with a dropped write during busy
      tx_capture(8'hA5, 1'b1);
      check_frame(10'b11_0100_1010);
      bus_read(ADDR_UCON, 32'h10, "ucon_tx_done");
      bus_read(ADDR_UCON, 32'h00, "ucon_cleared");
      bus_read(ADDR_TXD, 32'hA5, "txd_readback");

      // RX with interrupt
      tick(1'b0, 1'b1, ADDR_UCON, 8'h02);
      rx_frame(8'h5A, 1'b1);
      check("irq_rx_set", 32'(irq), 32'd1);
      bus_read(ADDR_UCON, 32'h06, "ucon_rx_valid");
      bus_read(ADDR_RXD, 32'h5A, "rxd_5a");
      check("irq_rx_clr", 32'(irq), 32'd0);

      // Overrun
      rx_frame(8'h11, 1'b1);
      rx_frame(8'h22, 1'b1);
      bus_read(ADDR_RXD, 32'h22, "rxd_overwrite");
      bus_read(ADDR_UCON, 32'h22, "ucon_overrun");
      bus_read(ADDR_UCON, 32'h02, "ucon_ovr_clr");

      // Frame error leaves rx_valid untouched
      rx_frame(8'h5A, 1'b1);
      rx_frame(8'h77, 1'b0);
      bus_read(ADDR_UCON, 32'h46, "ucon_frame_err");
      bus_read(ADDR_UCON, 32'h06, "ucon_ferr_clr");

      // Short glitch on the line is ignored
      $display("rx    glitch 4 clocks");
      m_rx_busy = 1'b1;
      uart_rx = 1'b0; idle(4);
      uart_rx = 1'b1; idle(24);
      m_rx_busy = 1'b0;
      bus_read(ADDR_UCON, 32'h06, "ucon_glitch");
      bus_read(ADDR_RXD, 32'h5A, "rxd_glitch");

      // Randomized traffic; model checks every cycle
      for (int it = 0; it < 2500; it++) begin
         if ($urandom_range(0, 99) < 4)
            rx_frame(8'($urandom), $urandom_range(0, 7) != 0);
         else
            tick(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                 addr_pool[$urandom_range(0, 5)], 8'($urandom));
      end

      // Reset in the middle of a TX frame
      for (int i = 0; i < 200 && m_tx_active; i++) idle(1);
      $display("txd   write=0x96 then reset mid-frame");
      tick(1'b0, 1'b1, ADDR_TXD, 8'h96);
      idle(70);
      check("tx_before_reset", 32'(uart_tx), 32'd0);
      #1 reset_n = 1'b0;
      model_reset();
      #1 check("tx_in_reset", 32'(uart_tx), 32'd1);
      bus_if.rd = 1'b1; bus_if.addr = ADDR_UCON;
      #1 check("ucon_in_reset", bus_if.rdata, 32'd0);
      bus_if.rd = 1'b0;
      idle(2);
      reset_n = 1'b1;
      tx_capture(8'hC3, 1'b0);
      check_frame(10'b11_1000_0110);
      bus_read(ADDR_UCON, 32'h10, "ucon_after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
